// File: rtl/sin_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sin_sched_pkg
// Purpose  : Shared types and constants for the time-shared sine ROM scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sin_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    localparam int ROM_LAT    = 1;
    // Address register plus the ROM's own read register.
    localparam int PIPE_DEPTH = ROM_LAT + 1;

    function automatic int mix_width(input int data_w, input int num_ch);
        return data_w + $clog2(num_ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sin_rom_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sin_rom_sched_if
// Purpose  : Control, ROM and sample/mix bus of the sine ROM scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sin_rom_sched_if
    import sin_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) ();
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int MIX_W = mix_width(DATA_WIDTH, NUM_CH);

    logic                   tick;
    logic [NUM_CH-1:0]      ch_en;
    logic                   wr_en;
    logic [CH_W-1:0]        wr_ch;
    logic [PHASE_WIDTH-1:0] wr_fcw;
    logic                   phase_clr;
    logic [ADDR_WIDTH-1:0]  rom_addr;
    logic [DATA_WIDTH-1:0]  rom_dout;
    logic                   smp_valid;
    logic [CH_W-1:0]        smp_ch;
    logic [DATA_WIDTH-1:0]  smp_data;
    logic                   mix_valid;
    logic [MIX_W-1:0]       mix_data;
    logic                   busy;
    logic                   tick_miss;

    modport master (
        output tick, ch_en, wr_en, wr_ch, wr_fcw, phase_clr, rom_dout,
        input  rom_addr, smp_valid, smp_ch, smp_data, mix_valid, mix_data,
               busy, tick_miss
    );

    modport slave (
        input  tick, ch_en, wr_en, wr_ch, wr_fcw, phase_clr, rom_dout,
        output rom_addr, smp_valid, smp_ch, smp_data, mix_valid, mix_data,
               busy, tick_miss
    );
endinterface
`default_nettype wire

// File: rtl/sin_phase_bank.sv
`default_nettype none
// ============================================================================
// Module   : sin_phase_bank
// Purpose  : Per-channel phase accumulators and FCW registers with step/clear.
// Revision : 1.0 - initial release
// ============================================================================
module sin_phase_bank
    import sin_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 8,
    parameter int CH_W        = $clog2(NUM_CH)
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    i_wr_en,
    input  wire [CH_W-1:0]         i_wr_ch,
    input  wire [PHASE_WIDTH-1:0]  i_wr_fcw,
    input  wire                    i_step,
    input  wire [CH_W-1:0]         i_step_ch,
    input  wire                    i_clr,
    input  wire [CH_W-1:0]         i_rd_ch,
    output logic [ADDR_WIDTH-1:0]  o_rd_msb
);
    logic [ADDR_WIDTH-1:0] w_msb [NUM_CH];

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic [PHASE_WIDTH-1:0] r_phase;
            logic [PHASE_WIDTH-1:0] r_fcw;

            // The step reads r_fcw before a same-cycle write lands.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_phase <= '0;
                    r_fcw   <= '0;
                end else begin
                    if (i_wr_en && (i_wr_ch == CH_W'(g)))
                        r_fcw <= i_wr_fcw;
                    if (i_clr)
                        r_phase <= '0;
                    else if (i_step && (i_step_ch == CH_W'(g)))
                        r_phase <= r_phase + r_fcw;
                end
            end

            assign w_msb[g] = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
        end
    endgenerate

    assign o_rd_msb = w_msb[i_rd_ch];

endmodule
`default_nettype wire

// File: rtl/sin_rom_sched.sv
`default_nettype none
// ============================================================================
// Module   : sin_rom_sched
// Purpose  : Round-robin sharing of one sine ROM among NUM_CH DDS channels,
//            with per-channel sample tagging and a per-frame signed mix.
// Revision : 1.0 - initial release
// ============================================================================
module sin_rom_sched
    import sin_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  wire            clk,
    input  wire            rst,
    sin_rom_sched_if.slave bus
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int MIX_W  = mix_width(DATA_WIDTH, NUM_CH);
    localparam int DCNT_W = $clog2(PIPE_DEPTH + 2);

    sched_state_t          r_state, w_state_nxt;
    logic [CH_W-1:0]       r_slot, w_slot_nxt;
    logic [DCNT_W-1:0]     r_dcnt, w_dcnt_nxt;
    logic                  w_start;
    logic                  w_mix_fire;
    logic                  w_busy;
    logic                  w_slot_act;
    logic                  w_clr;
    logic [ADDR_WIDTH-1:0] w_rd_msb;

    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [PIPE_DEPTH-1:0] r_pv;
    logic [CH_W-1:0]       r_pch [PIPE_DEPTH];
    logic                  r_smp_valid;
    logic [CH_W-1:0]       r_smp_ch;
    logic [DATA_WIDTH-1:0] r_smp_data;
    logic [MIX_W-1:0]      r_acc;
    logic                  r_mix_valid;
    logic [MIX_W-1:0]      r_mix_data;
    logic                  r_tick_miss;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_slot_act = (r_state == ST_RUN) && bus.ch_en[r_slot];
    assign w_clr      = bus.phase_clr && (r_state == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_dcnt_nxt  = r_dcnt;
        w_start     = 1'b0;
        w_mix_fire  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.tick) begin
                    w_state_nxt = ST_RUN;
                    w_slot_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_slot == CH_W'(NUM_CH - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_slot_nxt = r_slot + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Last sample leaves the ROM PIPE_DEPTH cycles into drain;
                // the accumulator settles one cycle later.
                if (r_dcnt == DCNT_W'(PIPE_DEPTH))
                    w_mix_fire = 1'b1;
                if (r_dcnt == DCNT_W'(PIPE_DEPTH + 1))
                    w_state_nxt = ST_IDLE;
                else
                    w_dcnt_nxt = r_dcnt + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    sin_phase_bank #(
        .NUM_CH      (NUM_CH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .CH_W        (CH_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_ch   (bus.wr_ch),
        .i_wr_fcw  (bus.wr_fcw),
        .i_step    (w_slot_act),
        .i_step_ch (r_slot),
        .i_clr     (w_clr),
        .i_rd_ch   (r_slot),
        .o_rd_msb  (w_rd_msb)
    );

    // Tag pipeline: stage 0 aligns with rom_addr, last stage with rom_dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_pv[i]  <= 1'b0;
                r_pch[i] <= '0;
            end
        end else begin
            if (w_slot_act)
                r_rom_addr <= w_rd_msb;
            r_pv[0]  <= w_slot_act;
            r_pch[0] <= r_slot;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pch[i] <= r_pch[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp_valid <= 1'b0;
            r_smp_ch    <= '0;
            r_smp_data  <= '0;
            r_acc       <= '0;
            r_mix_valid <= 1'b0;
            r_mix_data  <= '0;
            r_tick_miss <= 1'b0;
        end else begin
            r_smp_valid <= r_pv[PIPE_DEPTH-1];
            if (r_pv[PIPE_DEPTH-1]) begin
                r_smp_ch   <= r_pch[PIPE_DEPTH-1];
                r_smp_data <= bus.rom_dout;
            end
            if (w_start)
                r_acc <= '0;
            else if (r_pv[PIPE_DEPTH-1])
                r_acc <= r_acc + {{(MIX_W-DATA_WIDTH){bus.rom_dout[DATA_WIDTH-1]}},
                                  bus.rom_dout};
            r_mix_valid <= w_mix_fire;
            if (w_mix_fire)
                r_mix_data <= r_acc;
            r_tick_miss <= bus.tick && w_busy;
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.smp_valid = r_smp_valid;
    assign bus.smp_ch    = r_smp_ch;
    assign bus.smp_data  = r_smp_data;
    assign bus.mix_valid = r_mix_valid;
    assign bus.mix_data  = r_mix_data;
    assign bus.busy      = w_busy;
    assign bus.tick_miss = r_tick_miss;

endmodule
`default_nettype wire

// File: tb/tb_sin_rom_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sin_rom_sched
// Purpose  : Directed self-checking bench for sin_rom_sched with a ROM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sin_rom_sched;
    import sin_sched_pkg::*;

    localparam int N  = 4;
    localparam int PW = 24;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int CW = 2;
    localparam int MW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sin_rom_sched_if #(.NUM_CH(N), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sin_rom_sched #(.NUM_CH(N), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [DW-1:0] rom_tab [256];
    always @(posedge clk) bus.rom_dout <= rom_tab[bus.rom_addr];

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } smp_t;

    smp_t          q[$];
    logic [PW-1:0] m_phase [N];
    logic [PW-1:0] m_fcw   [N];
    int            n_vec = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_addr"},  32'(bus.rom_addr),  0);
        check({tag, "_smp_valid"}, 32'(bus.smp_valid), 0);
        check({tag, "_smp_ch"},    32'(bus.smp_ch),    0);
        check({tag, "_smp_data"},  32'(bus.smp_data),  0);
        check({tag, "_mix_valid"}, 32'(bus.mix_valid), 0);
        check({tag, "_mix_data"},  32'(bus.mix_data),  0);
        check({tag, "_busy"},      32'(bus.busy),      0);
        check({tag, "_tick_miss"}, 32'(bus.tick_miss), 0);
    endtask

    task automatic write_fcw(input int ch, input logic [PW-1:0] v);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_ch = CW'(ch); bus.wr_fcw = v;
        @(negedge clk);
        bus.wr_en = 1'b0;
        m_fcw[ch] = v;
    endtask

    task automatic clear_phases();
        @(negedge clk);
        bus.phase_clr = 1'b1;
        @(negedge clk);
        bus.phase_clr = 1'b0;
        for (int k = 0; k < N; k++) m_phase[k] = '0;
    endtask

    // One frame with optional extra tick, FCW write, clear-with-tick and clear-while-busy.
    task automatic frame(input logic [N-1:0] en, input int miss_at, input int wr_at,
                         input int wr_c, input logic [PW-1:0] wr_v, input bit clr0,
                         input int clr_at, input int gap);
        logic [AW-1:0] e_addr [N];
        logic [MW-1:0] e_mix;
        logic [PW-1:0] f;
        logic [DW-1:0] d;
        smp_t          s;
        bit            e_v;
        e_mix = '0;
        if (clr0) for (int k = 0; k < N; k++) m_phase[k] = '0;
        for (int k = 0; k < N; k++) begin
            e_addr[k] = '0;
            f = (wr_at >= 0 && wr_c == k && wr_at < 1 + k) ? wr_v : m_fcw[k];
            if (en[k]) begin
                e_addr[k] = m_phase[k][PW-1 -: AW];
                d = rom_tab[e_addr[k]];
                q.push_back('{ch: k, data: d});
                e_mix = e_mix + {{(MW-DW){d[DW-1]}}, d};
                m_phase[k] = m_phase[k] + f;
            end
        end
        if (wr_at >= 0) m_fcw[wr_c] = wr_v;

        @(negedge clk);
        bus.tick = 1'b1; bus.ch_en = en; bus.phase_clr = clr0;
        for (int n = 1; n <= N + 6; n++) begin
            @(negedge clk);
            bus.tick      = (n == miss_at);
            bus.phase_clr = (n == clr_at);
            bus.wr_en     = (n == wr_at);
            bus.wr_ch     = CW'(wr_c);
            bus.wr_fcw    = wr_v;
            check($sformatf("busy@%0d", n), 32'(bus.busy), 32'(n <= N + 4));
            check($sformatf("mix_valid@%0d", n), 32'(bus.mix_valid), 32'(n == N + 4));
            check($sformatf("tick_miss@%0d", n), 32'(bus.tick_miss),
                  32'(miss_at >= 0 && n == miss_at + 1));
            if (n == N + 4)
                check("mix_data", 32'(bus.mix_data), 32'(e_mix));
            if (n >= 2 && n < 2 + N && en[n-2])
                check($sformatf("rom_addr_ch%0d", n - 2), 32'(bus.rom_addr), 32'(e_addr[n-2]));
            e_v = 1'b0;
            if (n >= 4 && n < 4 + N) e_v = en[n-4];
            check($sformatf("smp_valid@%0d", n), 32'(bus.smp_valid), 32'(e_v));
            if (bus.smp_valid === 1'b1 && q.size() > 0) begin
                s = q.pop_front();
                check($sformatf("smp_ch@%0d", n),   32'(bus.smp_ch),   32'(s.ch));
                check($sformatf("smp_data@%0d", n), 32'(bus.smp_data), 32'(s.data));
            end
        end
        check("queue_drained", q.size(), 0);
        bus.tick = 1'b0; bus.phase_clr = 1'b0; bus.wr_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic tone(input logic [N-1:0] en);
        frame(en, -1, -1, 0, '0, 1'b0, -1, 9);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            real r;
            int  v;
            r = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(a) / 256.0);
            if (r >= 0.0) v = $rtoi(r + 0.5);
            else          v = -$rtoi(0.5 - r);
            rom_tab[a] = v[DW-1:0];
        end
        for (int k = 0; k < N; k++) begin m_phase[k] = '0; m_fcw[k] = '0; end
        bus.tick = 1'b0; bus.ch_en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0;
        bus.wr_fcw = '0; bus.phase_clr = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Slow tone on channel 0 only.
        write_fcw(0, 24'h010000);
        repeat (3) tone(4'b0001);

        // Quarter-cycle steps cover +full-scale, -full-scale and wrap.
        write_fcw(0, 24'h400000);
        clear_phases();
        repeat (5) tone(4'b0001);

        // All channels in phase.
        for (int k = 1; k < N; k++) write_fcw(k, 24'h400000);
        clear_phases();
        repeat (3) tone(4'b1111);

        // Disabled channels hold phase; later frame reads them from 0.
        clear_phases();
        repeat (2) tone(4'b0101);
        tone(4'b1010);

        // Missed tick plus FCW write coinciding with ch2's slot.
        frame(4'b1111, 3, 3, 2, 24'h200000, 1'b0, -1, 4);
        tone(4'b1111);
        // Clear while busy is ignored; clear with tick restarts from 0.
        frame(4'b1111, -1, -1, 0, '0, 1'b0, 2, 4);
        tone(4'b1111);
        frame(4'b1111, -1, -1, 0, '0, 1'b1, -1, 4);

        // Reset mid-frame.
        @(negedge clk);
        bus.tick = 1'b1; bus.ch_en = 4'b1111;
        @(negedge clk);
        bus.tick = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1 check_all_zero("midreset");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mix_valid_in_reset", 32'(bus.mix_valid), 0);
        end
        rst = 1'b0;
        q.delete();
        for (int k = 0; k < N; k++) begin m_phase[k] = '0; m_fcw[k] = '0; end
        repeat (2) @(negedge clk);
        tone(4'b1111);
        for (int k = 0; k < N; k++) write_fcw(k, 24'h400000);
        repeat (2) tone(4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
